// File: rtl/encoder16_pending.sv
// Sequential priority encoder: gathers one-hot request pulses into a pending set
// and issues indices lowest-first over a valid/ready output slot.
module encoder16_pending #(
  parameter int N     = 4,
  parameter int CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [(2**N)-1:0]   req,
  input  logic                clr,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [N-1:0]        out_code,
  output logic [(2**N)-1:0]   pending,
  output logic [CNT_W-1:0]    pending_cnt,
  output logic                overflow
);

  localparam int W = 2**N;

  logic             slot_free;
  logic             load;
  logic [N-1:0]     sel;
  logic [W-1:0]     load_mask;
  logic [W-1:0]     pending_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             dup;

  assign slot_free = !out_valid || out_ready;
  assign load      = slot_free && (pending != '0);

  // Scan high-to-low so the lowest set bit wins.
  always_comb begin
    sel = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (pending[i]) sel = N'(i);
    end
  end

  // The loaded bit is cleared before req is merged, so a same-cycle
  // re-request keeps the index pending and counts as a fresh request.
  assign load_mask   = load ? (W'(1) << sel) : '0;
  assign pending_nxt = (pending & ~load_mask) | req;
  assign dup         = |(req & pending & ~load_mask);

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < W; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(pending_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      pending_cnt <= '0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
      out_code    <= '0;
    end else if (clr) begin
      pending     <= '0;
      pending_cnt <= '0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
      out_code    <= '0;
    end else begin
      pending     <= pending_nxt;
      pending_cnt <= cnt_nxt;
      if (dup) overflow <= 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_code  <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encoder16_pending.sv
// Scenario bench for encoder16_pending: expected codes are queued when requests
// are driven and popped by a consumer monitor on every accepted handshake.
module tb_encoder16_pending;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        clr;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_code;
  logic [15:0] pending;
  logic [4:0]  pending_cnt;
  logic        overflow;

  int checks = 0;
  int passed = 0;
  logic [3:0] exp_q[$];

  encoder16_pending #(.N(4), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .clr        (clr),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_code   (out_code),
    .pending    (pending),
    .pending_cnt(pending_cnt),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer: a handshake seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [3:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL handshake_unexpected: got code %0d, no code expected", out_code);
      end else begin
        e = exp_q.pop_front();
        if (out_code !== e)
          $display("FAIL handshake_code: got %0d, expected %0d", out_code, e);
        else
          passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    else passed++;
  endtask

  task automatic chk_drained(input string name);
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s: %0d codes never issued, expected 0", name, exp_q.size());
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req = '0; clr = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_pending", 32'(pending), 32'h0);
    chk("reset_cnt", 32'(pending_cnt), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_code", 32'(out_code), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    exp_q.push_back(4'd4);
    req = 16'h0010; tick(); req = '0;
    chk("single_pending", 32'(pending), 32'h0010);
    chk("single_cnt", 32'(pending_cnt), 32'd1);
    chk("single_valid_early", 32'(out_valid), 32'h0);
    tick();
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_code", 32'(out_code), 32'd4);
    chk("single_pending_after", 32'(pending), 32'h0);
    tick();
    chk("single_valid_drop", 32'(out_valid), 32'h0);
    chk_drained("single_drained");
  endtask

  task automatic test_priority();
    logic [3:0] codes [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
    out_ready = 1'b1;
    foreach (codes[k]) exp_q.push_back(codes[k]);
    req = 16'h8421; tick(); req = '0;
    chk("prio_cnt_start", 32'(pending_cnt), 32'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("prio_code", 32'(out_code), 32'(codes[k]));
      chk("prio_cnt", 32'(pending_cnt), 32'(3 - k));
    end
    tick();
    chk("prio_valid_drop", 32'(out_valid), 32'h0);
    chk("prio_overflow", 32'(overflow), 32'h0);
    chk_drained("prio_drained");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    req = 16'h0006; tick(); req = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_held", 32'(out_valid), 32'h1);
      chk("bp_code_held", 32'(out_code), 32'd1);
      chk("bp_pending_held", 32'(pending), 32'h0004);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_code_next", 32'(out_code), 32'd2);
    chk("bp_pending_empty", 32'(pending), 32'h0);
    tick();
    chk("bp_valid_drop", 32'(out_valid), 32'h0);
    chk_drained("bp_drained");
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd4);
    req = 16'h0008; tick(); req = '0;
    tick();
    chk("ovf_slot_code", 32'(out_code), 32'd3);
    // Index 3 sits only in the slot: re-requesting it is not a duplicate.
    req = 16'h0008; tick(); req = '0;
    chk("ovf_slot_rereq", 32'(overflow), 32'h0);
    chk("ovf_rereq_pending", 32'(pending), 32'h0008);
    req = 16'h0018; tick(); req = '0;
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_pending", 32'(pending), 32'h0018);
    chk("ovf_cnt", 32'(pending_cnt), 32'd2);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("ovf_valid_drop", 32'(out_valid), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    chk_drained("ovf_drained");
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'h0);
  endtask

  task automatic test_rereq_on_load();
    out_ready = 1'b1;
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    req = 16'h0001; tick();
    tick(); req = '0;
    chk("rl_code", 32'(out_code), 32'd0);
    chk("rl_pending_kept", 32'(pending), 32'h0001);
    chk("rl_overflow", 32'(overflow), 32'h0);
    tick();
    chk("rl_code_again", 32'(out_code), 32'd0);
    chk("rl_pending_empty", 32'(pending), 32'h0);
    tick();
    chk("rl_valid_drop", 32'(out_valid), 32'h0);
    chk_drained("rl_drained");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(4'(k));
    req = 16'hFFFF; tick(); req = '0;
    chk("b2b_cnt_full", 32'(pending_cnt), 32'd16);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("b2b_code", 32'(out_code), 32'(k));
      chk("b2b_cnt", 32'(pending_cnt), 32'(15 - k));
    end
    tick();
    chk("b2b_valid_drop", 32'(out_valid), 32'h0);
    chk_drained("b2b_drained");
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    req = 16'hFFFF; tick();
    tick(); req = '0;
    chk("clr_pre_pending", 32'(pending), 32'hFFFF);
    chk("clr_pre_valid", 32'(out_valid), 32'h1);
    clr = 1'b1; req = 16'h0002; tick();
    clr = 1'b0; req = '0;
    chk("clr_pending", 32'(pending), 32'h0);
    chk("clr_cnt", 32'(pending_cnt), 32'h0);
    chk("clr_valid", 32'(out_valid), 32'h0);
    chk("clr_code", 32'(out_code), 32'h0);
    chk("clr_overflow", 32'(overflow), 32'h0);
    tick();
    chk("clr_req_dropped", 32'(pending), 32'h0);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    req = 16'h0030; tick(); req = '0;
    tick();
    chk("ar_pre_valid", 32'(out_valid), 32'h1);
    chk("ar_pre_code", 32'(out_code), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pending", 32'(pending), 32'h0);
    chk("ar_cnt", 32'(pending_cnt), 32'h0);
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_code", 32'(out_code), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_stays_idle", 32'(out_valid), 32'h0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_overflow();
    test_rereq_on_load();
    test_back_to_back();
    test_clear();
    test_async_reset();
    chk_drained("final_drained");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
